// File: rtl/input_debounce4.sv
// input_debounce4: four-lane sync + debounce front end with a single-grant
// arbiter so the downstream encoder only ever sees one-hot or all-zero.

// Per-lane synchroniser and debouncer.
module input_debounce4_lane #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop sync, then flip stable only after DB_CYCLES consecutive disagreements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

module input_debounce4 #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inA,
  input  logic inB,
  input  logic inC,
  input  logic inD,
  output logic outA,
  output logic outB,
  output logic outC,
  output logic outD,
  output logic outValid,
  output logic outPress
);

  localparam int NUM_LANES = 4;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  // Lane index 0..3 maps to A..D; lower index has higher priority.
  logic [NUM_LANES-1:0] w_raw;
  logic [NUM_LANES-1:0] w_stable;

  assign w_raw = {inD, inC, inB, inA};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    input_debounce4_lane #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (w_raw[g]),
      .o_stable(w_stable[g])
    );
  end

  state_t               r_state;
  logic [1:0]           r_grant;
  logic [NUM_LANES-1:0] r_out;
  logic                 r_valid;
  logic                 r_press;

  state_t               w_state_nxt;
  logic [1:0]           w_grant_nxt;
  logic [NUM_LANES-1:0] w_out_nxt;
  logic                 w_valid_nxt;
  logic                 w_press_nxt;

  // State, grant index and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= 2'd0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_press <= w_press_nxt;
    end
  end

  // Next state: grab the highest-priority stable lane from IDLE, hold until it drops.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    case (r_state)
      S_IDLE: begin
        if (|w_stable) begin
          w_state_nxt = S_HOLD;
          if (w_stable[0])      w_grant_nxt = 2'd0;
          else if (w_stable[1]) w_grant_nxt = 2'd1;
          else if (w_stable[2]) w_grant_nxt = 2'd2;
          else                  w_grant_nxt = 2'd3;
        end
      end
      S_HOLD: begin
        if (!w_stable[r_grant]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state; a release always lands in IDLE for a cycle.
  always_comb begin
    w_out_nxt = '0;
    if (w_state_nxt == S_HOLD) w_out_nxt[w_grant_nxt] = 1'b1;
    w_valid_nxt = (w_state_nxt == S_HOLD);
    w_press_nxt = (r_state == S_IDLE) && (w_state_nxt == S_HOLD);
  end

  assign outA     = r_out[0];
  assign outB     = r_out[1];
  assign outC     = r_out[2];
  assign outD     = r_out[3];
  assign outValid = r_valid;
  assign outPress = r_press;

endmodule

// File: doc/input_debounce4.md
# input_debounce4

Four-channel input conditioner that sits directly upstream of the 4-to-2 `encoder`. It synchronises four raw asynchronous request lines and debounces each one independently. It then presents at most one active line at a time on `outA`..`outD`, which drive the encoder's `inA`..`inD`. This guarantees the encoder only ever sees a clean one-hot or all-zero input.

## Interface
- `DB_CYCLES`, default 4: number of consecutive clock cycles a synchronised input must differ from its debounced state before that state flips. Legal range is 1..2^CNT_W−1.
- `CNT_W`, default 3: width of each per-channel debounce counter.
- `clk`  input  1: single clock. All flops are clocked on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `inA`, `inB`, `inC`, `inD`  input  1 each: raw asynchronous request lines.
- `outA`, `outB`, `outC`, `outD`  output  1 each: granted, debounced request. At most one is high at any time. These feed the encoder `inA`..`inD`.
- `outValid`  output  1: high while any `out*` is high.
- `outPress`  output  1: one-cycle pulse on the cycle a new grant appears.

## Operation
- Synchroniser:
  - Each raw input passes through two flops, `sync1` then `sync2`.
  - Only `sync2` is used downstream.
- Debounce, per channel, with a `stable` flop and a CNT_W-bit `cnt`:
  - If `sync2 == stable`: `cnt` <= 0.
  - If `sync2 != stable` and `cnt == DB_CYCLES−1`: `stable` <= `sync2`, `cnt` <= 0.
  - If `sync2 != stable` otherwise: `cnt` <= `cnt`+1.
  - Any return of `sync2` to `stable` before the count completes clears `cnt`. The glitch is discarded.
- Grant FSM, two states, IDLE and HOLD, with a 2-bit `grant` index:
  - In IDLE, all `out*` are 0. If any `stable` bit is 1, the FSM latches the index of the highest-priority set bit, with priority A > B > C > D. It then drives that `out*` to 1 and `outPress` to 1, and moves to HOLD.
  - In HOLD, the granted `out*` stays 1 and all others stay 0. Other channels becoming stable are ignored.
  - When `stable[grant]` is 0 in HOLD, all `out*` go to 0 and the FSM returns to IDLE.
  - IDLE always lasts at least one cycle, so there is a guaranteed one-cycle all-zero gap between consecutive grants.
- Output registers:
  - `outA`..`outD`, `outValid` and `outPress` are all registered.
  - `outValid` = (state == HOLD).
  - `outPress` is high only on the first HOLD cycle.
- Reset: asserting `rst_n` low immediately clears every flop, asynchronously. This covers the synchronisers, `stable`, `cnt`, the FSM (forced to IDLE) and all outputs (forced to 0).

## Timing
- Reset values: `outA`..`outD` = 0, `outValid` = 0, `outPress` = 0, state = IDLE, all `cnt` = 0, all `stable` = 0.
- Press latency: a raw rise that stays high appears on `out*` DB_CYCLES+3 rising edges after it. The edges are:
  - `sync1` at edge 1.
  - `sync2` at edge 2.
  - `stable` at edge 2+DB_CYCLES.
  - `out` at edge 3+DB_CYCLES.
  - With the default DB_CYCLES = 4, `out*` rises at edge 7.
- Release latency: the granted `out*` falls DB_CYCLES+3 edges after its raw input falls.
- Re-grant: the earliest next grant is one edge after a release edge.
- Glitch rejection: any `sync2` excursion shorter than DB_CYCLES cycles produces no change in `stable`.
- Simultaneous stabilisation in IDLE: the highest-priority channel wins and the losers stay pending.
- A pending loser is granted after the gap if its `stable` bit is still 1.
- If the granted channel releases in the same cycle another channel stabilises, the release takes effect first. The other channel is granted one edge later.
- Reset asserted mid-HOLD: outputs drop to 0 without waiting for a clock edge, and no `outPress` is produced.
- Raw input already high at reset release: it is treated as a new press and is granted at edge DB_CYCLES+3 after release.

## Test plan
(DB_CYCLES = 4, 10 ns clock.)
- Hold `rst_n` low with `inB` = 1, then release at t0 -> all outputs are 0 during reset. `outB`, `outValid` and `outPress` rise at the 7th edge after t0. `outPress` is low one cycle later and `outB` stays 1.
- Pulse `inC` high for 2 cycles, then low -> `outC`, `outValid` and `outPress` remain 0 throughout.
- Raise `inB` and `inD` in the same cycle, then drop `inB` -> only `outB` rises (edge 7). `outB` falls 7 edges after `inB` falls, followed by exactly one all-zero cycle. `outD` and `outPress` rise on the next edge.
- Toggle `inA` every cycle for 6 cycles, then hold it high -> `outA` rises exactly 7 edges after the final rising transition, with a single `outPress`.
- With `outC` granted, pull `rst_n` low between edges -> all outputs go to 0 before the next edge. After release with `inC` still high, `outC` is re-granted at edge 7.
- Drive the encoder-style pattern (A/B/C/D toggling every 400/200/100/50 ns) for 800 ns -> at most one `out*` is high at every edge, and every grant is preceded by at least one all-zero cycle.
